// File: rtl/dsc_pkg.sv
// Shared types and helpers for the stochastic-multiplier scheduler.
package dsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_RESP
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

  // Width of a requester ID; a single requester still gets a 1-bit field.
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsc_mul_sched_if.sv
// Request/response bundle between compute clients and the multiplier scheduler.
interface dsc_mul_sched_if
  import dsc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 5,
  parameter int WXIP1      = 10
);
  localparam int IW = ID_W(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IW-1:0]                 rsp_id;
  logic [WXIP1-1:0]              rsp_data;
  logic                          rsp_timeout;

  // Client side: raises requests and consumes responses.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_timeout
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last+1, with wrap.
module rr_arbiter
  import dsc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [ID_W(N)-1:0] last,
  output logic [N-1:0]       grant
);
  localparam int IW = ID_W(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsc_mul_sched.sv
// Round-robin scheduler sharing one deterministic-stochastic serial multiplier among NUM_REQ clients.
module dsc_mul_sched
  import dsc_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 5,
  parameter int WXIP1        = 10,
  parameter int DRAIN_CYCLES = 1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  dsc_mul_sched_if.slave        bus,
  output logic                  mul_rst,
  output logic                  mul_en,
  output logic [DATA_WIDTH-1:0] mul_op_a,
  output logic [DATA_WIDTH-1:0] mul_op_b,
  input  logic                  mul_done,
  input  logic [WXIP1-1:0]      mul_result
);
  localparam int IW      = ID_W(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  sched_state_t          state;
  logic [IW-1:0]         last_grant;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_id;
  logic [DATA_WIDTH-1:0] grant_a;
  logic [DATA_WIDTH-1:0] grant_b;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic [IW-1:0]         rsp_id_q;
  logic [WXIP1-1:0]      rsp_data_q;
  logic                  rsp_to_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = IW'(i);
        grant_a  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        grant_b  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Moore decodes of the state register; req_ready never sees rsp_ready.
  assign bus.req_ready   = (state == S_IDLE) ? grant : '0;
  assign bus.rsp_valid   = (state == S_RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign mul_en          = (state == S_RUN);
  assign mul_rst         = rst | (state == S_CLR);
  assign mul_op_a        = op_a_q;
  assign mul_op_b        = op_b_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all registers here are control/datapath flops, so all are reset; an in-flight job is dropped.
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      cnt        <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            op_a_q     <= grant_a;
            op_b_q     <= grant_b;
            rsp_id_q   <= grant_id;
            last_grant <= grant_id;
            rsp_to_q   <= 1'b0;
            state      <= S_CLR;
          end
        end
        S_CLR: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          // A done seen in the first RUN cycle is a leftover overflow from the previous job.
          if (cnt != '0 && mul_done) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else if (cnt == RUN_LAST) begin
            rsp_to_q <= 1'b1;
            cnt      <= '0;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + CW'(1);
          if (cnt == DRAIN_LAST) begin
            rsp_data_q <= mul_result;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dsc_mul_sched.md
# dsc_mul_sched

Round-robin scheduler that shares one deterministic-stochastic serial multiplier (stride-4 SNG chain plus parallel accumulator) among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the multiplier through clear, enable and completion. It captures the binary result and returns it with the requester ID over a single valid/ready response channel. It sits between the arch-sweep compute clients and the multiplier instance; the multiplier itself is unchanged.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥1.
- `DATA_WIDTH`, 5: operand width, matching the multiplier's `DATA_WIDTH`.
- `WXIP1`, 10: result width, matching the multiplier's `bin_data_out`.
- `DRAIN_CYCLES`, 1: cycles between accepted `mul_done` and result capture (accumulator flush), ≥1.
- `TIMEOUT`, 1024: maximum RUN cycles before forced capture.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester.
- `req_ready`  out  `NUM_REQ`  one-hot accept pulse.
- `req_a`  in  `NUM_REQ*DATA_WIDTH`  operand A; requester i is slice i.
- `req_b`  in  `NUM_REQ*DATA_WIDTH`  operand B; requester i is slice i.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  `$clog2(NUM_REQ)` (min 1)  ID of the requester being answered.
- `rsp_data`  out  `WXIP1`  product count.
- `rsp_timeout`  out  1  response was forced by the watchdog.
- `mul_rst`  out  1  multiplier clear.
- `mul_en`  out  1  multiplier enable.
- `mul_op_a`, `mul_op_b`  out  `DATA_WIDTH`  operands driven to the multiplier (`bin_data_in[0]`, `bin_data_in[1]`).
- `mul_done`  in  1  multiplier done (last SNG overflow).
- `mul_result`  in  `WXIP1`  multiplier binary output.

## Operation
States: IDLE, CLR, RUN, DRAIN, RESP.

- **IDLE.** If any `req_valid` bit is set, grant the first set bit found by searching upward, with wrap, from `last_grant+1`. In the same cycle:
  - pulse `req_ready[g]`;
  - latch `req_a[g]` and `req_b[g]` into the operand registers;
  - latch `g` into `rsp_id` and `last_grant`;
  - go to CLR.

  With no valid request, remain in IDLE.
- **CLR.** Lasts 1 cycle. `mul_rst`=1 and `mul_en`=0. Clear the cycle counter. Go to RUN.
- **RUN.** `mul_en`=1 and the counter increments each cycle.
  - `mul_done` is ignored in the first RUN cycle (stale-overflow guard).
  - After that, `mul_done`=1 goes to DRAIN.
  - When counter = `TIMEOUT`-1 without `mul_done`, set the timeout flag and go to DRAIN.
- **DRAIN.** `mul_en`=0. Lasts `DRAIN_CYCLES` cycles. On the last cycle, register `mul_result` into `rsp_data` and go to RESP.
- **RESP.** `rsp_valid`=1 until a cycle with `rsp_ready`=1, then go to IDLE. The next grant is possible on the cycle after the handshake.
- **Operands.** `mul_op_a` and `mul_op_b` hold their latched values from CLR through DRAIN.
- **Fairness.** `last_grant` resets to `NUM_REQ`-1, so requester 0 has first priority after reset. A requester that drops `req_valid` before its grant is simply skipped.

## Timing
- **Reset values:**
  - state = IDLE;
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_timeout`=0, `mul_en`=0;
  - `mul_rst`=1 while `rst` is asserted (combinational OR with `rst`);
  - `mul_op_a`/`mul_op_b`=0.
- **Latency.** From the accept cycle T: `mul_rst` at T+1, `mul_en` from T+2. With `mul_done` sampled at cycle D, `rsp_valid` rises at D+`DRAIN_CYCLES`+1.
- **Output decoding.** `req_ready` is decoded from the state register, has no combinational path from `rsp_ready`, and is 0 outside IDLE. `mul_en` and `mul_rst` are Moore outputs.
- **Simultaneous events:**
  - `mul_done` and timeout in the same cycle: `rsp_timeout`=0.
  - `rsp_ready` held high before `rsp_valid`: the handshake completes in the first RESP cycle.
- **Reset mid-operation.** Abort immediately, discard the in-flight request without a response, and deassert `mul_en`.

## Structure
- Shared package `dsc_pkg`: the state enum `sched_state_t`, the `ID_W` function, and the default `TIMEOUT` constant.
- One natural sub-module, `rr_arbiter` (parameter `N`): inputs `req`, `last`; output one-hot `grant`. It is purely combinational, with the registered `last` kept in the parent.
- No other hierarchy. The multiplier is instantiated outside the block.

## Test plan
1. **Single request.** Requester 0 sends A=16, B=8. The model asserts `mul_done` 64 cycles after `mul_en` rises, with `mul_result`=128. Expect: `mul_rst` for 1 cycle, `mul_en` for 64 cycles, then `rsp_valid` with `rsp_id`=0, `rsp_data`=128, `rsp_timeout`=0.
2. **All four requesters valid continuously.** Expect grant order 0,1,2,3,0, each `req_ready` a single-cycle one-hot pulse, and responses carrying matching IDs and operand products.
3. **Backpressure.** `rsp_ready`=0 for 20 cycles in RESP. Expect `rsp_valid` and `rsp_data` stable, no new `req_ready`, and the next grant on the cycle after the handshake.
4. **Watchdog.** `TIMEOUT`=32 and `mul_done` never asserts. Expect DRAIN after 32 RUN cycles and a response with `rsp_timeout`=1.
5. **Stale done.** `mul_done` held high in the first RUN cycle, then low until cycle 10. Expect RUN to last exactly 10 cycles.
6. **Reset mid-RUN.** Assert `rst` at RUN cycle 5. Expect immediate `mul_en`=0, all outputs at reset values, no response, and requester 0 granted first after release.
